// File: rtl/oserdes_gearbox.sv
// Multi-lane parallel-to-serial gearbox: one IN_W word per lane every R clocks,
// OUT_W bits per lane per clock, with a one-word skid (hold) and idle-word fill on underrun.
module oserdes_gearbox #(
   parameter int               CHANNELS  = 3,
   parameter int               IN_W      = 10,
   parameter int               OUT_W     = 2,
   parameter bit               LSB_FIRST = 1'b1,
   parameter logic [IN_W-1:0]  IDLE_WORD = IN_W'('h354)
) (
   input  logic                      i_clk,
   input  logic                      i_arst_n,
   input  logic [CHANNELS*IN_W-1:0]  i_pdata,
   input  logic                      i_valid,
   output logic                      o_ready,
   output logic [CHANNELS*OUT_W-1:0] o_sdata,
   output logic                      o_word_start,
   output logic                      o_underrun,
   input  logic                      i_clr_underrun
);
   localparam int               R     = IN_W / OUT_W;
   localparam int               CNT_W = (R > 1) ? $clog2(R) : 1;
   localparam logic [CNT_W-1:0] LAST  = CNT_W'(R - 1);

   logic [CNT_W-1:0] cnt_reg;
   logic             hold_v_reg;
   logic             armed_reg;
   logic             word_start_reg;
   logic             underrun_reg;

   logic load;
   logic accept;
   logic bypass;
   logic from_hold;
   logic starve;

   assign load      = (cnt_reg == LAST);
   assign o_ready   = !hold_v_reg || load;
   assign accept    = i_valid && o_ready;
   assign from_hold = load && hold_v_reg;
   // An empty hold on the load edge lets the incoming word go straight into the shifter.
   assign bypass    = load && !hold_v_reg && i_valid;
   assign starve    = load && !hold_v_reg && !i_valid;

   always_ff @(posedge i_clk or negedge i_arst_n) begin
      if (!i_arst_n) begin
         cnt_reg        <= '0;
         hold_v_reg     <= 1'b0;
         armed_reg      <= 1'b0;
         word_start_reg <= 1'b0;
         underrun_reg   <= 1'b0;
      end else begin
         word_start_reg <= (cnt_reg == '0);
         cnt_reg        <= load ? '0 : cnt_reg + CNT_W'(1);
         if (accept) begin
            armed_reg <= 1'b1;
         end
         if (accept && !bypass) begin
            hold_v_reg <= 1'b1;
         end else if (from_hold) begin
            hold_v_reg <= 1'b0;
         end
         // Idle fill before the first accepted word is expected, so it is not an underrun.
         if (starve && armed_reg) begin
            underrun_reg <= 1'b1;
         end else if (i_clr_underrun) begin
            underrun_reg <= 1'b0;
         end
      end
   end

   assign o_word_start = word_start_reg;
   assign o_underrun   = underrun_reg;

   for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_lane
      logic [IN_W-1:0]  sh_reg;
      logic [IN_W-1:0]  sh_next;
      logic [IN_W-1:0]  hold_reg;
      logic [IN_W-1:0]  word_in;
      logic [OUT_W-1:0] sdata_reg;
      logic [OUT_W-1:0] slice;

      assign word_in = i_pdata[gi*IN_W +: IN_W];
      assign slice   = LSB_FIRST ? sh_reg[OUT_W-1:0] : sh_reg[IN_W-1 -: OUT_W];

      always_comb begin
         sh_next = LSB_FIRST ? (sh_reg >> OUT_W) : (sh_reg << OUT_W);
         if (load) begin
            if (hold_v_reg) begin
               sh_next = hold_reg;
            end else if (i_valid) begin
               sh_next = word_in;
            end else begin
               sh_next = IDLE_WORD;
            end
         end
      end

      always_ff @(posedge i_clk or negedge i_arst_n) begin
         if (!i_arst_n) begin
            sh_reg    <= IDLE_WORD;
            hold_reg  <= '0;
            sdata_reg <= '0;
         end else begin
            sh_reg    <= sh_next;
            sdata_reg <= slice;
            if (accept && !bypass) begin
               hold_reg <= word_in;
            end
         end
      end

      assign o_sdata[gi*OUT_W +: OUT_W] = sdata_reg;
   end

endmodule

// File: tb/tb_oserdes_gearbox.sv
// Scoreboard bench for oserdes_gearbox: an LSB-first and an MSB-first instance share
// stimulus; monitors rebuild each serialised word and compare it with the expected stream.
module tb_oserdes_gearbox;
   localparam int CH    = 3;
   localparam int IN_W  = 10;
   localparam int OUT_W = 2;
   localparam int R     = IN_W / OUT_W;
   localparam int CW    = CH * IN_W;
   localparam int SW    = CH * OUT_W;
   localparam logic [CW-1:0] IDLE3 = {3{10'h354}};
   localparam logic [CW-1:0] WORD_A = {10'h3FF, 10'h000, 10'h3A5};
   localparam logic [CW-1:0] WORD_B = {10'h0F0, 10'h2AA, 10'h155};
   localparam logic [CW-1:0] WORD_D1 = {10'h2EF, 10'h1CD, 10'h0AB};
   localparam logic [CW-1:0] WORD_D2 = {10'h111, 10'h0C3, 10'h3C3};

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [CW-1:0] pdata = '0;
   logic          valid = 1'b0;
   logic          clr = 1'b0;
   logic          ready_l, ready_m;
   logic [SW-1:0] sdata_l, sdata_m;
   logic          ws_l, ws_m;
   logic          urun_l, urun_m;

   int cmp_count = 0;
   int err_count = 0;
   int t = 0;

   logic [CW-1:0] exp_q[$];
   int            rd_idx[2];
   int            idx[2];
   bit            synced[2];
   logic [CW-1:0] got_w[2];
   logic [SW-1:0] mon_s;
   logic          mon_ws;

   always #5 clk = ~clk;

   oserdes_gearbox #(.CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(1'b1),
                     .IDLE_WORD(10'h354)) dut_l (
      .i_clk(clk), .i_arst_n(rst_n), .i_pdata(pdata), .i_valid(valid), .o_ready(ready_l),
      .o_sdata(sdata_l), .o_word_start(ws_l), .o_underrun(urun_l), .i_clr_underrun(clr));

   oserdes_gearbox #(.CHANNELS(CH), .IN_W(IN_W), .OUT_W(OUT_W), .LSB_FIRST(1'b0),
                     .IDLE_WORD(10'h354)) dut_m (
      .i_clk(clk), .i_arst_n(rst_n), .i_pdata(pdata), .i_valid(valid), .o_ready(ready_m),
      .o_sdata(sdata_m), .o_word_start(ws_m), .o_underrun(urun_m), .i_clr_underrun(clr));

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      cmp_count++;
      if (got !== exp) begin
         err_count++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0d, time %0t)", name, got, exp, t, $time);
      end
   endtask

   task automatic chk2(input string name, input logic a_l, input logic a_m, input logic exp);
      check({name, "_lsb"}, {31'd0, a_l}, {31'd0, exp});
      check({name, "_msb"}, {31'd0, a_m}, {31'd0, exp});
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
      t += n;
   endtask

   function automatic logic [CW-1:0] stream_word(input int j);
      return {10'(10'h100 + j), 10'(10'h3FF - j), 10'(j * 37 + 5)};
   endfunction

   // Monitor: rebuilds one word per lane from R consecutive slices after o_word_start.
   always @(negedge clk) begin
      for (int m = 0; m < 2; m++) begin
         mon_s  = (m == 0) ? sdata_l : sdata_m;
         mon_ws = (m == 0) ? ws_l : ws_m;
         if (!rst_n) begin
            synced[m] = 1'b0;
            idx[m]    = 0;
            rd_idx[m] = 0;
            check(m == 0 ? "rst_sdata_lsb" : "rst_sdata_msb", 32'(mon_s), 32'd0);
            check(m == 0 ? "rst_ws_lsb" : "rst_ws_msb", 32'(mon_ws), 32'd0);
         end else begin
            if (!synced[m] && mon_ws) synced[m] = 1'b1;
            if (synced[m]) begin
               check(m == 0 ? "ws_phase_lsb" : "ws_phase_msb", 32'(mon_ws), 32'(idx[m] == 0));
               for (int c = 0; c < CH; c++) begin
                  int pos;
                  pos = (m == 0) ? idx[m] * OUT_W : IN_W - (idx[m] + 1) * OUT_W;
                  got_w[m][c*IN_W + pos +: OUT_W] = mon_s[c*OUT_W +: OUT_W];
               end
               idx[m]++;
               if (idx[m] == R) begin
                  idx[m] = 0;
                  if (rd_idx[m] >= exp_q.size()) begin
                     cmp_count++;
                     err_count++;
                     $display("FAIL word_extra_%0d: got 0x%0h, expected no word", m, got_w[m]);
                  end else begin
                     check(m == 0 ? "word_lsb" : "word_msb", 32'(got_w[m]), 32'(exp_q[rd_idx[m]]));
                     $display("word[%0d] lane-order %0s: 0x%08h", rd_idx[m], m == 0 ? "lsb" : "msb", got_w[m]);
                     rd_idx[m]++;
                  end
               end
            end
         end
      end
   end

   initial begin
      int j;
      int guard;
      logic acc;

      // Expected word stream up to the mid-word reset.
      repeat (4) exp_q.push_back(IDLE3);
      exp_q.push_back(WORD_A);
      repeat (4) exp_q.push_back(IDLE3);
      for (int k = 0; k < 6; k++) exp_q.push_back(stream_word(k));
      exp_q.push_back(IDLE3);
      exp_q.push_back(WORD_B);
      exp_q.push_back(IDLE3);

      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      t = 0;
      chk2("ready_first", ready_l, ready_m, 1'b1);

      // Idle only: no underrun while never armed.
      for (int k = 0; k < 15; k++) begin
         step(1);
         chk2("idle_urun", urun_l, urun_m, 1'b0);
         chk2("idle_ready", ready_l, ready_m, 1'b1);
      end

      // Single word through hold.
      valid = 1'b1;
      pdata = WORD_A;
      step(1);
      valid = 1'b0;
      for (int k = 16; k < 20; k++) begin
         chk2("hold_ready", ready_l, ready_m, (t == 19));
         step(1);
      end
      step(4);
      chk2("urun_pre", urun_l, urun_m, 1'b0);
      step(1);
      chk2("urun_set", urun_l, urun_m, 1'b1);

      // Clear, then re-set on the next starved load; set wins over a simultaneous clear.
      step(1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk2("urun_clr", urun_l, urun_m, 1'b0);
      step(3);
      chk2("urun_reset", urun_l, urun_m, 1'b1);
      step(4);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      chk2("urun_set_wins", urun_l, urun_m, 1'b1);

      // Sustained stream at t=40.
      step(5);
      valid = 1'b1;
      pdata = stream_word(0);
      clr = 1'b1;
      j = 0;
      guard = 0;
      while (j < 6 && guard < 60) begin
         chk2("stream_ready", ready_l, ready_m, ((t - 40) == 0) || (((t - 40) % 5) == 4));
         acc = ready_l;
         step(1);
         clr = 1'b0;
         guard++;
         chk2("stream_urun", urun_l, urun_m, 1'b0);
         if (acc) begin
            j++;
            if (j < 6) pdata = stream_word(j);
            else valid = 1'b0;
         end
      end
      check("stream_end_t", 32'(t), 32'd65);
      step(9);
      chk2("stream_tail_urun", urun_l, urun_m, 1'b0);
      step(1);
      chk2("stream_after_urun", urun_l, urun_m, 1'b1);

      // Bypass on the load cycle.
      step(1);
      clr = 1'b1;
      step(1);
      clr = 1'b0;
      step(2);
      valid = 1'b1;
      pdata = WORD_B;
      chk2("bypass_ready", ready_l, ready_m, 1'b1);
      step(1);
      valid = 1'b0;
      chk2("bypass_hold_empty", ready_l, ready_m, 1'b1);
      chk2("bypass_urun", urun_l, urun_m, 1'b0);
      step(1);
      chk2("bypass_ws", ws_l, ws_m, 1'b1);
      check("bypass_slice0_lsb", 32'(sdata_l), 32'h09);
      check("bypass_slice0_msb", 32'(sdata_m), 32'h09);
      step(4);
      chk2("bypass_after_urun", urun_l, urun_m, 1'b1);

      // Fill shifter and hold, then reset at slice 2.
      valid = 1'b1;
      pdata = WORD_D1;
      step(1);
      valid = 1'b0;
      step(3);
      chk2("d1_load_ready", ready_l, ready_m, 1'b1);
      step(1);
      valid = 1'b1;
      pdata = WORD_D2;
      chk2("d2_ready", ready_l, ready_m, 1'b1);
      step(1);
      valid = 1'b0;
      chk2("hold_full_ready", ready_l, ready_m, 1'b0);
      step(2);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_sdata_lsb", 32'(sdata_l), 32'd0);
      check("arst_sdata_msb", 32'(sdata_m), 32'd0);
      chk2("arst_ws", ws_l, ws_m, 1'b0);
      chk2("arst_urun", urun_l, urun_m, 1'b0);
      chk2("arst_ready", ready_l, ready_m, 1'b1);
      check("words_seen_lsb", 32'(rd_idx[0]), 32'd18);
      check("words_seen_msb", 32'(rd_idx[1]), 32'd18);
      exp_q.delete();
      repeat (3) exp_q.push_back(IDLE3);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      t = 0;
      step(16);
      chk2("post_rst_urun", urun_l, urun_m, 1'b0);
      chk2("post_rst_ready", ready_l, ready_m, 1'b1);
      check("post_rst_words_lsb", 32'(rd_idx[0]), 32'd3);
      check("post_rst_words_msb", 32'(rd_idx[1]), 32'd3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, err_count);
      $finish;
   end
endmodule

// File: doc/oserdes_gearbox.md
# oserdes_gearbox

Parametrised multi-channel parallel-to-serial gearbox running in a single clock domain. It accepts one IN_W-bit word per channel through a valid/ready handshake and emits OUT_W bits per channel per clock, LSB- or MSB-first. When no word is available it inserts a programmable idle word and flags the underrun. It sits between TMDS/line encoders and narrow-width output primitives (OUT_W=2 for DDR, OUT_W=1 for SDR pins).

## Interface
- CHANNELS, 3, number of lanes; all lanes share handshake and slice counter.
- IN_W, 10, parallel word width per channel.
- OUT_W, 2, serial slice width per channel per clock. R = IN_W/OUT_W must be an integer ≥ 2.
- LSB_FIRST, 1, 1: slice 0 = bits [OUT_W-1:0]; 0: slice 0 = bits [IN_W-1:IN_W-OUT_W].
- IDLE_WORD, 10'h354, IN_W-bit word inserted on underrun and after reset (TMDS control token).
- i_clk  in  1  sole clock.
- i_arst_n  in  1  reset, asynchronous and active-low.
- i_pdata  in  CHANNELS*IN_W  channel c at [c*IN_W +: IN_W].
- i_valid  in  1  i_pdata valid.
- o_ready  out  1  word accepted on the edge where i_valid & o_ready.
- o_sdata  out  CHANNELS*OUT_W  registered slice, channel c at [c*OUT_W +: OUT_W].
- o_word_start  out  1  high in the cycle o_sdata carries slice 0 of any word (data or idle).
- o_underrun  out  1  sticky underrun flag.
- i_clr_underrun  in  1  synchronous clear of o_underrun.

## Operation
- State: per-channel shifter sh (IN_W) and hold register hold (IN_W); shared hold_v, slice counter cnt in 0..R-1, armed flag.
- Reset (async, i_arst_n=0): sh=IDLE_WORD for all channels, hold_v=0, cnt=0, armed=0, o_sdata=0, o_word_start=0, o_underrun=0.
- Every cycle: o_sdata <= the current slice of sh (low OUT_W bits if LSB_FIRST, else high OUT_W bits); o_word_start <= (cnt==0).
- cnt<R-1: shift sh by OUT_W (right if LSB_FIRST, left otherwise; vacated bits 0); cnt++.
- cnt==R-1 (load cycle): cnt<=0. sh is loaded from:
  - hold, if hold_v=1;
  - i_pdata (bypass), else if i_valid=1;
  - IDLE_WORD otherwise. If armed=1, o_underrun<=1.
- o_ready = !hold_v | (cnt==R-1). Combinational from state only, never from i_valid.
- Accept (i_valid & o_ready):
  - Write hold, hold_v<=1, armed<=1.
  - Exception: the bypass case above loads sh directly and leaves hold_v=0.
- Load from hold with no simultaneous accept: hold_v<=0.
- Load from hold with simultaneous accept: hold takes the new word, hold_v stays 1.
- i_clr_underrun clears o_underrun; a simultaneous set wins. armed is cleared only by reset.
- i_pdata is ignored when i_valid=0. Channels are never independently stalled.

## Timing
- Period: one word per R clocks. Sustained full rate requires i_valid held high; backpressure occurs only while hold is full and cnt≠R-1.
- After reset:
  - o_ready=1 in the first cycle.
  - The idle word is serialised first.
  - The first o_word_start is in the second cycle after reset release (o_sdata registered).
- Latency, bypass accept on load edge k: slice 0 on o_sdata after edge k+1, with o_word_start=1. Slices 1..R-1 follow on consecutive cycles.
- Latency, accept into hold: slice 0 appears one cycle after the next load edge.
- Reset asserted mid-word: outputs and state return to reset values immediately. The partial word and any held word are discarded; no underrun is flagged.
- Storage is 2 words (sh + hold). No word is ever dropped or duplicated while the handshake is honoured.

## Test plan
Defaults: CHANNELS=3, IN_W=10, OUT_W=2, R=5, IDLE_WORD=10'h354.
- Reset, no input: ch0 o_sdata repeats 0,1,1,1,3 (0x354 LSB-first). o_word_start every 5th cycle. o_underrun stays 0; o_ready=1.
- Single word 0x3A5 on ch0 (ch1 0x000, ch2 0x3FF) accepted via hold: ch0 emits 1,1,2,2,3; ch1 emits 0s; ch2 emits 3s. Idle resumes after. o_underrun=1 after the first idle load following the word.
- Same test with LSB_FIRST=0: ch0 emits 3,2,2,1,1.
- i_valid held high with an incrementing word stream: o_ready low for 4 of every 5 cycles. Every word appears exactly once, in order, with no idle inserted and o_underrun=0.
- Bypass: hold empty, word presented only in the cycle cnt==4. Accepted with hold_v staying 0; slice 0 appears 2 edges later with o_word_start=1.
- Assert i_arst_n=0 at slice 2 of a data word with hold full: o_sdata=0 and o_word_start=0 immediately. The idle pattern restarts after release; the held word is never emitted. Pulse i_clr_underrun to confirm the flag clears and re-sets on the next true underrun.
